arm_multicycle_controller: RTL and testbench

Control unit for the multicycle ARM processor. It decodes the latched instruction, holds the NZCV condition flags, and steps a Moore state machine that drives every datapath enable and multiplexer select. One datapath operation runs per cycle: instruction fetch, register read, ALU, memory access and writeback. Instruction and data traffic share one unified memory port, which the controller time-multiplexes through `AdrSrc`.

---
 rtl/arm_multicycle_controller.sv | 242 ++++++++++++++++++++++++
 tb/tb_arm_multicycle_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_multicycle_controller.sv
// Multicycle ARM control unit: instruction decode, NZCV flag register,
// condition evaluation and the Moore state machine that sequences the
// datapath one operation per cycle over a shared memory port.
module arm_multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic [1:0]  ResultSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUControl,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  Flags
);

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    state_t      state_reg, state_next, out_state;
    logic [3:0]  flags_reg;

    // Instruction fields; Instr carries bits [31:12] of the instruction word
    logic [3:0]  cond;
    logic [1:0]  op;
    logic        imm_i;
    logic [3:0]  cmd;
    logic        s_bit;
    logic        up;
    logic        rd_is_pc;
    logic        unused_rn;

    assign cond      = Instr[19:16];
    assign op        = Instr[15:14];
    assign imm_i     = Instr[13];
    assign cmd       = Instr[12:9];
    assign s_bit     = Instr[8];
    assign up        = Instr[11];
    assign rd_is_pc  = (Instr[3:0] == 4'd15);
    assign unused_rn = ^Instr[7:4];

    logic [1:0]  dp_alu;
    logic        no_write;
    logic        cv_write;
    logic        cond_ex;

    // Data-processing command decode; unknown commands act as a non-writing ADD
    always_comb begin
        dp_alu   = ALU_ADD;
        no_write = 1'b0;
        case (cmd)
            4'b0100: dp_alu = ALU_ADD;
            4'b0010: dp_alu = ALU_SUB;
            4'b0000: dp_alu = ALU_AND;
            4'b1100: dp_alu = ALU_ORR;
            4'b1010: begin
                dp_alu   = ALU_SUB;
                no_write = 1'b1;
            end
            default: begin
                dp_alu   = ALU_ADD;
                no_write = 1'b1;
            end
        endcase
    end

    // Carry and overflow are only meaningful for arithmetic operations
    assign cv_write = (dp_alu == ALU_ADD) || (dp_alu == ALU_SUB);

    // ARM condition table evaluated against the registered flags
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags_reg;
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = z;
            4'h1: cond_ex = ~z;
            4'h2: cond_ex = c;
            4'h3: cond_ex = ~c;
            4'h4: cond_ex = n;
            4'h5: cond_ex = ~n;
            4'h6: cond_ex = v;
            4'h7: cond_ex = ~v;
            4'h8: cond_ex = c & ~z;
            4'h9: cond_ex = ~c | z;
            4'hA: cond_ex = (n == v);
            4'hB: cond_ex = (n != v);
            4'hC: cond_ex = ~z & (n == v);
            4'hD: cond_ex = z | (n != v);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // While reset is held the outputs present the FETCH selects
    assign out_state = reset ? S_FETCH : state_reg;

    logic ir_w, reg_w, mem_w, next_pc, branch, flag_w;

    // Next-state logic and Moore outputs of the control sequencer
    always_comb begin
        state_next = state_reg;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        next_pc    = 1'b0;
        branch     = 1'b0;
        flag_w     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_ADD;

        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_DP:   state_next = imm_i ? S_EXECI : S_EXECR;
                    OP_MEM:  state_next = S_MEMADR;
                    OP_B:    state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = s_bit ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  state_next = S_ALUWB;
            default:  state_next = S_FETCH;
        endcase

        case (out_state)
            S_FETCH: begin
                ir_w       = 1'b1;
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ALUControl = ALU_ADD;
                next_pc    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                ALUControl = ALU_ADD;
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ALUControl = up ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD:  AdrSrc = 1'b1;
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_EXECR: begin
                ALUSrcB    = 2'b00;
                ALUControl = dp_alu;
                flag_w     = 1'b1;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = dp_alu;
                flag_w     = 1'b1;
            end
            S_ALUWB: begin
                ResultSrc = 2'b00;
                reg_w     = ~no_write;
            end
            S_BRANCH: begin
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                ResultSrc  = 2'b10;
                branch     = 1'b1;
            end
            default: ;
        endcase
    end

    // A register write that targets R15 redirects the PC like a branch
    assign PCWrite  = ~reset & (next_pc | ((branch | (reg_w & rd_is_pc)) & cond_ex));
    assign IRWrite  = ~reset & ir_w;
    assign RegWrite = ~reset & reg_w & cond_ex;
    assign MemWrite = ~reset & mem_w & cond_ex;
    assign ImmSrc   = op;
    assign RegSrc   = {(op == OP_MEM) & ~s_bit, (op == OP_B)};
    assign Flags    = flags_reg;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_FETCH;
        else       state_reg <= state_next;
    end

    // Per-bit flag registers: N,Z (bits 3,2) on any flag-setting op, C,V only for arithmetic
    logic flag_upd;
    assign flag_upd = flag_w & s_bit & cond_ex;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_flag
            localparam bit IS_NZ = (gi >= 2);
            // Capture this flag bit from the ALU at the end of an enabled execute step
            always_ff @(posedge clk) begin
                if (reset)
                    flags_reg[gi] <= 1'b0;
                else if (flag_upd && (IS_NZ || cv_write))
                    flags_reg[gi] <= ALUFlags[gi];
            end
        end
    endgenerate

endmodule

// File: tb/tb_arm_multicycle_controller.sv
// Self-checking bench for arm_multicycle_controller: directed scenarios plus
// randomized instructions, compared every cycle against a path-based model.
module tb_arm_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
    logic [3:0]  Flags;

    arm_multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags)
    );

    always #5 clk = ~clk;

    // Bit 15 PCWrite, 13 MemWrite, 11 RegWrite
    logic [15:0] dut_vec;
    assign dut_vec = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                      ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

    localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MEMADR = 2, PH_MEMRD = 3,
                   PH_MEMWB = 4, PH_MEMWR = 5, PH_EXECR = 6, PH_EXECI = 7,
                   PH_ALUWB = 8, PH_BRANCH = 9;

    int          total = 0;
    int          passes = 0;
    logic [3:0]  model_flags;
    int          path[$];
    logic [15:0] obs_q[$];

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return cy;
            4'h3: return !cy;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return cy && !z;
            4'h9: return !cy || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {NoWrite, ALU operation} for a data-processing command
    function automatic logic [2:0] dp_decode(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 3'b0_00;
            4'b0010: return 3'b0_01;
            4'b0000: return 3'b0_10;
            4'b1100: return 3'b0_11;
            4'b1010: return 3'b1_01;
            default: return 3'b1_00;
        endcase
    endfunction

    function automatic logic [15:0] model_out(input int ph, input logic [19:0] ins,
                                              input logic [3:0] fl, input logic rst);
        logic pcw, adr, memw, irw, regw, srca, nextpc, br, ce;
        logic [1:0] res, srcb, alu;
        logic [2:0] d;
        int p;
        p = rst ? PH_FETCH : ph;
        {pcw, adr, memw, irw, regw, srca, nextpc, br} = '0;
        res = 2'b00; srcb = 2'b00; alu = 2'b00;
        d = dp_decode(ins[12:9]);
        case (p)
            PH_FETCH:  begin irw = 1; srca = 1; srcb = 2'b10; res = 2'b10; nextpc = 1; end
            PH_DECODE: begin srca = 1; srcb = 2'b10; res = 2'b10; end
            PH_MEMADR: begin srcb = 2'b01; alu = ins[11] ? 2'b00 : 2'b01; end
            PH_MEMRD:  adr = 1;
            PH_MEMWR:  begin adr = 1; memw = 1; end
            PH_MEMWB:  begin res = 2'b01; regw = 1; end
            PH_EXECR:  alu = d[1:0];
            PH_EXECI:  begin srcb = 2'b01; alu = d[1:0]; end
            PH_ALUWB:  regw = !d[2];
            PH_BRANCH: begin srcb = 2'b01; res = 2'b10; br = 1; end
            default: ;
        endcase
        ce   = cond_holds(ins[19:16], fl);
        pcw  = nextpc || ((br || (regw && ins[3:0] == 4'd15)) && ce);
        regw = regw && ce;
        memw = memw && ce;
        if (rst) begin pcw = 0; irw = 0; regw = 0; memw = 0; end
        return {pcw, adr, memw, irw, regw, res, srca, srcb, alu, ins[15:14],
                (ins[15:14] == 2'b01) && !ins[8], ins[15:14] == 2'b10};
    endfunction

    function automatic void build_path(input logic [19:0] ins);
        path.delete();
        path.push_back(PH_FETCH);
        path.push_back(PH_DECODE);
        case (ins[15:14])
            2'b00: begin path.push_back(ins[13] ? PH_EXECI : PH_EXECR); path.push_back(PH_ALUWB); end
            2'b01: begin
                path.push_back(PH_MEMADR);
                if (ins[8]) begin path.push_back(PH_MEMRD); path.push_back(PH_MEMWB); end
                else path.push_back(PH_MEMWR);
            end
            2'b10: path.push_back(PH_BRANCH);
            default: ;
        endcase
    endfunction

    // One clock cycle: drive, compare at negedge, advance the flag model at the edge
    task automatic step(input int ph, input logic [19:0] ins, input logic [3:0] af,
                        input logic rst, output logic [15:0] obs);
        logic [15:0] exp_vec;
        logic [3:0]  exp_flags;
        Instr = ins; ALUFlags = af; reset = rst;
        exp_vec   = model_out(ph, ins, model_flags, rst);
        exp_flags = model_flags;
        @(negedge clk);
        obs = dut_vec;
        total++;
        if (dut_vec === exp_vec) passes++;
        else $display("FAIL outputs ph=%0d instr=%05h rst=%0b: got %04h required %04h",
                      ph, ins, rst, dut_vec, exp_vec);
        total++;
        if (Flags === exp_flags) passes++;
        else $display("FAIL flags ph=%0d instr=%05h: got %b required %b", ph, ins, Flags, exp_flags);
        @(posedge clk);
        if (rst) model_flags = 4'b0000;
        else if ((ph == PH_EXECR || ph == PH_EXECI) && ins[8] && cond_holds(ins[19:16], model_flags)) begin
            model_flags[3:2] = af[3:2];
            if (!(ins[12:9] == 4'b0000 || ins[12:9] == 4'b1100)) model_flags[1:0] = af[1:0];
        end
        #1;
    endtask

    task automatic run_instr(input logic [19:0] ins, input logic [3:0] af, input int abort_at);
        logic [15:0] o;
        int n;
        build_path(ins);
        obs_q.delete();
        n = path.size();
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                step(path[k], ins, 4'($urandom), 1'b1, o);
                obs_q.push_back(o);
                break;
            end
            if (path[k] == PH_EXECR || path[k] == PH_EXECI) step(path[k], ins, af, 1'b0, o);
            else step(path[k], ins, 4'($urandom), 1'b0, o);
            obs_q.push_back(o);
        end
        $display("instr %05h cycles %0d abort %0d flags %b", ins, obs_q.size(), abort_at, Flags);
    endtask

    task automatic check_lit(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act === req) passes++;
        else $display("FAIL %s: got %b required %b", name, act, req);
    endtask

    function automatic logic [19:0] mk(input logic [3:0] c, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        return {c, op, funct, 4'd2, rd};
    endfunction

    initial begin
        logic [15:0] o;
        logic [19:0] ins;
        int abort_at;
        reset = 1'b1; Instr = '0; ALUFlags = '0;
        model_flags = 4'b0000;
        @(posedge clk); @(posedge clk); #1;
        // Reset held: FETCH selects, no enables, flags cleared
        step(PH_FETCH, 20'h0, 4'hF, 1'b1, o);
        check_lit("reset_pcwrite_irwrite", {2'b00, o[15], o[12]}, 4'b0000);

        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'd1), 4'hF, -1);          // ADD R1
        check_lit("add_flags", Flags, 4'b0000);
        check_lit("add_regwrite_aluwb", {3'b0, obs_q[3][11]}, 4'b0001);
        run_instr(mk(4'hE, 2'b00, 6'b000101, 4'd4), 4'b0100, -1);       // SUBS
        check_lit("subs_flags", Flags, 4'b0100);
        run_instr(mk(4'h0, 2'b00, 6'b001000, 4'd5), 4'hF, -1);          // ADDEQ
        check_lit("addeq_regwrite", {3'b0, obs_q[3][11]}, 4'b0001);
        run_instr(mk(4'h1, 2'b00, 6'b001000, 4'd6), 4'hF, -1);          // ADDNE
        check_lit("addne_regwrite", {3'b0, obs_q[3][11]}, 4'b0000);
        check_lit("addne_cycles", 4'(obs_q.size()), 4'd4);
        run_instr(mk(4'hE, 2'b01, 6'b011001, 4'd7), 4'h0, -1);          // LDR
        check_lit("ldr_cycles", 4'(obs_q.size()), 4'd5);
        check_lit("ldr_memwb_regwrite", {3'b0, obs_q[4][11]}, 4'b0001);
        run_instr(mk(4'hE, 2'b01, 6'b011000, 4'd7), 4'h0, -1);          // STR
        check_lit("str_memwrite", {3'b0, obs_q[3][13]}, 4'b0001);
        run_instr(mk(4'h0, 2'b10, 6'b100000, 4'd0), 4'h0, -1);          // BEQ taken
        check_lit("beq_taken_pcwrite", {3'b0, obs_q[2][15]}, 4'b0001);
        run_instr(mk(4'hE, 2'b00, 6'b010101, 4'd0), 4'b0110, -1);       // CMP
        check_lit("cmp_flags", Flags, 4'b0110);
        check_lit("cmp_regwrite", {3'b0, obs_q[3][11]}, 4'b0000);
        run_instr(mk(4'hE, 2'b00, 6'b000001, 4'd3), 4'b1011, -1);       // ANDS
        check_lit("ands_flags", Flags, 4'b1010);
        run_instr(mk(4'hE, 2'b01, 6'b011000, 4'd7), 4'h0, 3);           // STR aborted in MEMWR
        check_lit("abort_memwrite", {3'b0, obs_q[3][13]}, 4'b0000);
        check_lit("abort_flags", Flags, 4'b0000);
        run_instr(mk(4'h0, 2'b10, 6'b100000, 4'd0), 4'h0, -1);          // BEQ not taken
        check_lit("beq_untaken_pcwrite", {3'b0, obs_q[2][15]}, 4'b0000);
        run_instr(mk(4'hE, 2'b00, 6'b001000, 4'd15), 4'h0, -1);         // ADD PC
        check_lit("add_pc_pcwrite", {3'b0, obs_q[3][15]}, 4'b0001);
        run_instr(mk(4'hE, 2'b11, 6'b000000, 4'd1), 4'h0, -1);          // undefined op
        check_lit("undef_cycles", 4'(obs_q.size()), 4'd2);

        for (int t = 0; t < 300; t++) begin
            ins = 20'($urandom);
            abort_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 4)) : -1;
            run_instr(ins, 4'($urandom), abort_at);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
